// File: rtl/read_synchronizer_pkg.sv
// Shared types and helpers for the FIFO read-side request synchronizer.
package read_sync_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StGap   = 2'b10
  } state_e;

  localparam int unsigned GapCntWidth = 4;

  function automatic int unsigned pend_max(input int unsigned width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/read_synchronizer_sync_edge_detect.sv
// Multi-flop synchronizer followed by a rising-edge detector on the synchronized level.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] valid_q;
  logic                   prev_q;

  // prev only follows the chain once post-reset zeros have flushed out, so a level held
  // high across reset release never looks like a fresh 0->1 transition.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= '0;
      valid_q <= '0;
      prev_q  <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= valid_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/read_synchronizer.sv
// Turns asynchronous consumer read requests into spaced single-cycle FIFO read strobes,
// queueing requests that arrive while the FIFO is empty or a read is in flight.
module read_synchronizer
  import read_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_WIDTH  = 3,
  parameter int unsigned MIN_GAP     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_from_FIFO,
  input  logic                  fifo_empty,
  output logic                  read_synch,
  output logic [PEND_WIDTH-1:0] pending_count,
  output logic                  overflow,
  output logic                  busy
);

  localparam logic [PEND_WIDTH-1:0]  PendMax = PEND_WIDTH'(pend_max(PEND_WIDTH));
  localparam logic [GapCntWidth-1:0] GapLoad = GapCntWidth'(MIN_GAP);
  localparam logic [GapCntWidth-1:0] GapLast = GapCntWidth'(1);

  logic                   req_event;
  state_e                 state_q, state_d;
  logic [GapCntWidth-1:0] gap_q, gap_d;
  logic [PEND_WIDTH-1:0]  pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   issue_take;
  logic                   pend_inc;
  logic                   pend_dec;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .clock     (clock),
    .reset     (reset),
    .async_in  (read_from_FIFO),
    .rise_pulse(req_event)
  );

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    issue_take = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((pend_q != '0 || req_event) && !fifo_empty) begin
          issue_take = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        state_d = StGap;
        gap_d   = GapLoad;
      end
      StGap: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // An event issued straight from an empty queue never enters the count.
    pend_inc = req_event && !(issue_take && pend_q == '0);
    pend_dec = issue_take && pend_q != '0;

    if (pend_inc && !pend_dec) begin
      if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      gap_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign read_synch    = (state_q == StIssue);
  assign pending_count = pend_q;
  assign overflow      = ovf_q;
  assign busy          = (state_q != StIdle) || (pend_q != '0);

endmodule

// File: tb/tb_read_synchronizer.sv
// Directed bench for read_synchronizer: reset masking, latency, queueing, saturation, reset.
module tb_read_synchronizer;

  logic       clock;
  logic       reset;
  logic       read_from_FIFO;
  logic       fifo_empty;
  logic       read_synch;
  logic [2:0] pending_count;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  read_synchronizer #(
    .SYNC_STAGES(2),
    .PEND_WIDTH (3),
    .MIN_GAP    (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .read_from_FIFO(read_from_FIFO),
    .fifo_empty    (fifo_empty),
    .read_synch    (read_synch),
    .pending_count (pending_count),
    .overflow      (overflow),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #3 clock = ~clock;

  // 8 ns request pulse; returns 5 ns after capture edge E0 (before edge E0+1).
  task automatic pulse();
    @(negedge clock);
    read_from_FIFO = 1'b1;
    @(posedge clock);
    #5;
    read_from_FIFO = 1'b0;
  endtask

  task automatic run_count(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clock);
      #1;
      if (read_synch === 1'b1) cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    reset          = 1'b0;
    read_from_FIFO = 1'b1;
    fifo_empty     = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || read_synch !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: got busy=%b read_synch=%b, expected 0 0", busy, read_synch);
    end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (pending_count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pend=%0d ovf=%b, expected 0 0", pending_count, overflow);
    end
    @(negedge clock);
    reset = 1'b1;
    run_count(10, n);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL reset_held_req_strobes: got %0d, expected 0", n);
    end
    checks++;
    if (pending_count !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_req_state: got pend=%0d busy=%b ovf=%b, expected 0 0 0",
               pending_count, busy, overflow);
    end
    @(negedge clock);
    read_from_FIFO = 1'b0;
    repeat (4) @(posedge clock);
  endtask

  task automatic test_single_pulse();
    int n;
    fifo_empty = 1'b0;
    pulse();
    @(posedge clock);
    #1;
    checks++;
    if (read_synch !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got read_synch=%b at E0+1, expected 0", read_synch);
    end
    @(posedge clock);
    #1;
    checks++;
    if (read_synch !== 1'b1 || pending_count !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_strobe: got rs=%b pend=%0d busy=%b, expected 1 0 1",
               read_synch, pending_count, busy);
    end
    @(posedge clock);
    #1;
    checks++;
    if (read_synch !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap: got rs=%b busy=%b, expected 0 1", read_synch, busy);
    end
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b, expected 0", busy);
    end
    run_count(8, n);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL single_extra_strobes: got %0d, expected 0", n);
    end
  endtask

  task automatic test_pending_drain();
    int n;
    int total;
    total = 0;
    @(negedge clock);
    fifo_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse();
      run_count(5, n);
      total += n;
    end
    run_count(3, n);
    total += n;
    checks++;
    if (total !== 0 || pending_count !== 3'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL queue3: got strobes=%0d pend=%0d busy=%b, expected 0 3 1",
               total, pending_count, busy);
    end
    @(negedge clock);
    fifo_empty = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      checks++;
      if (read_synch !== 1'b1 || pending_count !== 3'(2 - k)) begin
        errors++;
        $display("FAIL drain_strobe%0d: got rs=%b pend=%0d, expected 1 %0d",
                 k, read_synch, pending_count, 2 - k);
      end
      repeat (2) begin
        @(posedge clock);
        #1;
        checks++;
        if (read_synch !== 1'b0) begin
          errors++;
          $display("FAIL drain_spacing%0d: got rs=%b, expected 0", k, read_synch);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_overflow();
    int n;
    int total;
    total = 0;
    @(negedge clock);
    fifo_empty = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse();
      run_count(5, n);
      total += n;
    end
    run_count(3, n);
    total += n;
    checks++;
    if (total !== 0 || pending_count !== 3'd7 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got strobes=%0d pend=%0d ovf=%b, expected 0 7 1",
               total, pending_count, overflow);
    end
    @(negedge clock);
    fifo_empty = 1'b0;
    run_count(25, n);
    checks++;
    if (n !== 7 || pending_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain: got strobes=%0d pend=%0d busy=%b, expected 7 0 0",
               n, pending_count, busy);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got ovf=%b, expected 1", overflow);
    end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_cleared: got ovf=%b, expected 0", overflow);
    end
  endtask

  task automatic test_event_during_issue();
    int n;
    @(negedge clock);
    fifo_empty = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pulse();
      run_count(5, n);
    end
    checks++;
    if (pending_count !== 3'd2) begin
      errors++;
      $display("FAIL coincide_setup: got pend=%0d, expected 2", pending_count);
    end
    // Release fifo_empty so the issue decision lands in the same cycle as req_event.
    pulse();
    @(posedge clock);
    @(negedge clock);
    fifo_empty = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (read_synch !== 1'b1 || pending_count !== 3'd2) begin
      errors++;
      $display("FAIL coincide_issue: got rs=%b pend=%0d, expected 1 2", read_synch, pending_count);
    end
    run_count(12, n);
    checks++;
    if (n !== 2 || pending_count !== 3'd0) begin
      errors++;
      $display("FAIL coincide_drain: got strobes=%0d pend=%0d, expected 2 0", n, pending_count);
    end
  endtask

  task automatic test_reset_mid_gap();
    int n;
    @(negedge clock);
    fifo_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse();
      run_count(5, n);
    end
    @(negedge clock);
    fifo_empty = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (read_synch !== 1'b1 || pending_count !== 3'd2) begin
      errors++;
      $display("FAIL midgap_issue: got rs=%b pend=%0d, expected 1 2", read_synch, pending_count);
    end
    @(posedge clock);
    #1;
    checks++;
    if (read_synch !== 1'b0 || busy !== 1'b1 || pending_count !== 3'd2) begin
      errors++;
      $display("FAIL midgap_gap: got rs=%b busy=%b pend=%0d, expected 0 1 2",
               read_synch, busy, pending_count);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (read_synch !== 1'b0 || pending_count !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midgap_reset: got rs=%b pend=%0d busy=%b ovf=%b, expected 0 0 0 0",
               read_synch, pending_count, busy, overflow);
    end
    @(negedge clock);
    reset = 1'b1;
    run_count(10, n);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL midgap_lost: got strobes=%0d, expected 0", n);
    end
    pulse();
    run_count(8, n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL midgap_new_req: got strobes=%0d, expected 1", n);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_pending_drain();
    test_overflow();
    test_event_during_issue();
    test_reset_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
